azadi_pinmux_cfg_ctrl: RTL
==========================

// Module: azadi_pinmux_cfg_ctrl
// PURPOSE
//  Register-programmed controller for the azadi_pin_mux select lines on IO[23:0].
//  Software writes a per-pin function select into shadow registers, then commits.
//  For each pin whose select changes, a glitch-free switch sequence runs:
//  gate OE low, switch the select, hold, then release.
//  Sits between the peripheral register bus and azadi_pin_mux (sel/oe gating).
// PARAMETERS
//  NUM_PINS      24  muxed IO pins under control
//  SEL_W         2   select width per pin (0 GPIO, 1 UART, 2 SPI, 3 PWM)
//  GUARD_CYCLES  4   cycles OE is gated before and after a switch (>=1)
//  AW            5   bus address width (must address NUM_PINS+2 words)
// PORTS
//  clk_i          in   1                 system clock
//  rst_ni         in   1                 asynchronous active-low reset
//  req_i          in   1                 bus request, single-cycle
//  we_i           in   1                 1=write, 0=read
//  addr_i         in   AW                word address
//  wdata_i        in   32                write data
//  rvalid_o       out  1                 response valid, one cycle after req_i
//  rdata_o        out  32                read data (valid with rvalid_o)
//  err_o          out  1                 error response (valid with rvalid_o)
//  pin_sel_o      out  NUM_PINS*SEL_W    active selects, pin i at [i*SEL_W +: SEL_W]
//  oe_gate_o      out  NUM_PINS          1=pin OE passes, 0=forced disabled
//  busy_o         out  1                 switch sequence in progress
//  commit_done_o  out  1                 one-cycle pulse at end of a commit
// BEHAVIOUR
//  Reset (async, rst_ni=0):
//   - shadow=0, pin_sel_o=0 (all GPIO), oe_gate_o=all 1s.
//   - busy_o, commit_done_o, rvalid_o, rdata_o, err_o = 0; FSM=IDLE.
//   - Reset mid-sequence aborts it immediately with the same values.
//  Register map (word addr):
//   0..NUM_PINS-1  SHADOW[a]: R/W; wdata[SEL_W-1:0] stored, upper bits ignored;
//                  reads return the zero-extended shadow value.
//   NUM_PINS       CTRL: write wdata[0]=1 -> commit; wdata[0]=0 is a no-op; reads 0.
//   NUM_PINS+1     STATUS: RO; bit0=busy_o; writes -> err.
//   other          err_o=1, rdata_o=0, no state change.
//  Bus timing:
//   - req_i sampled at cycle T; rvalid_o=1 at T+1 with rdata_o and err_o; req_i held high = one access per cycle.
//   - SHADOW writes are always accepted, including while busy; they take effect at the next commit.
//  Commit accepted at T, not busy:
//   - Snapshot pend=shadow; chg[i]=(pend[i]!=active[i]).
//   - chg==0: no sequence; busy_o stays 0; commit_done_o pulses at T+1.
//  FSM IDLE->GATE->SWITCH->HOLD->IDLE:
//   - GATE  T+1..T+G (G=GUARD_CYCLES): busy_o=1; oe_gate_o[i]=~chg[i].
//   - SWITCH T+G+1: active<=pend; pin_sel_o shows the new value from T+G+2.
//   - HOLD  T+G+2..T+2G+1: gating unchanged.
//   - IDLE  T+2G+2: oe_gate_o=all 1s, busy_o=0, commit_done_o=1 for one cycle.
//   - Unchanged pins are never gated; their select bits never toggle.
//  Commit while busy: err_o=1; ignored; running sequence unaffected.
//  Guard counter: width clog2(GUARD_CYCLES+1); reloads on entry to GATE and HOLD; no wrap.
// TESTING
//  1 Reset: release rst_ni -> pin_sel_o=0, oe_gate_o=24'hFFFFFF, busy_o=0, rvalid_o=0.
//  2 Write SHADOW[3]=32'hFFFF_FFF1, then read addr 3 -> rdata_o=32'h1, err_o=0;
//    pin_sel_o unchanged.
//  3 Set SHADOW[3]=1 and SHADOW[7]=2, commit at T (G=4) -> oe_gate_o=~(bits3,7) T+1..T+9;
//    pin_sel_o[7:6]=01 and [15:14]=10 from T+6; commit_done_o at T+10; busy_o 0 at T+10.
//  4 Commit with shadow==active -> busy_o never 1, commit_done_o pulse at T+1,
//    oe_gate_o stays all 1s.
//  5 Commit during GATE -> err_o=1 at next cycle; timing of test 3 unchanged;
//    read addr 30 -> err_o=1, rdata_o=0; write addr 25 -> err_o=1.
//  6 Assert rst_ni=0 during HOLD -> pin_sel_o=0, oe_gate_o all 1s, busy_o=0 immediately;
//    after release a commit runs normally.

Source files
------------

// File: rtl/azadi_pinmux_cfg_ctrl.sv
// azadi_pinmux_cfg_ctrl
// Register-programmed controller for the azadi_pin_mux select lines. Software
// fills per-pin shadow selects, then commits; every pin whose select changes
// has its OE gated off around the switch so the pad never sees a glitch.
module azadi_pinmux_cfg_ctrl #(
    parameter int NUM_PINS     = 24,
    parameter int SEL_W        = 2,
    parameter int GUARD_CYCLES = 4,
    parameter int AW           = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [AW-1:0]             addr_i,
    input  logic [31:0]               wdata_i,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic [NUM_PINS*SEL_W-1:0] pin_sel_o,
    output logic [NUM_PINS-1:0]       oe_gate_o,
    output logic                      busy_o,
    output logic                      commit_done_o
);

    localparam int               CNT_W       = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [AW-1:0]    CTRL_ADDR   = AW'(NUM_PINS);
    localparam logic [AW-1:0]    STATUS_ADDR = AW'(NUM_PINS + 1);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        SWITCH,
        HOLD
    } state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            guardCnt_q, guardCnt_d;
    logic [NUM_PINS*SEL_W-1:0]   shadow_q, shadow_d;
    logic [NUM_PINS*SEL_W-1:0]   pend_q, pend_d;
    logic [NUM_PINS*SEL_W-1:0]   active_q, active_d;
    logic [NUM_PINS-1:0]         chg_q, chg_d;
    logic [NUM_PINS-1:0]         chgNow;
    logic                        rvalid_q;
    logic [31:0]                 rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic                        done_q, done_d;
    logic                        commitReq;
    logic                        unused_wdata;

    // Upper write-data bits carry no meaning for this register map.
    assign unused_wdata = ^wdata_i[31:SEL_W];

    assign busy_o        = (state_q != IDLE);
    assign pin_sel_o     = active_q;
    assign oe_gate_o     = (state_q == IDLE) ? {NUM_PINS{1'b1}} : ~chg_q;
    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign err_o         = err_q;
    assign commit_done_o = done_q;

    // Bus decode: shadow updates, read data, error flag and commit request.
    always_comb begin
        shadow_d  = shadow_q;
        rdata_d   = 32'h0;
        err_d     = 1'b0;
        commitReq = 1'b0;
        if (req_i) begin
            if (addr_i < CTRL_ADDR) begin
                for (int i = 0; i < NUM_PINS; i++) begin
                    if (addr_i == AW'(i)) begin
                        if (we_i) begin
                            shadow_d[i*SEL_W +: SEL_W] = wdata_i[SEL_W-1:0];
                        end else begin
                            rdata_d = 32'(shadow_q[i*SEL_W +: SEL_W]);
                        end
                    end
                end
            end else if (addr_i == CTRL_ADDR) begin
                if (we_i && wdata_i[0]) begin
                    if (busy_o) begin
                        err_d = 1'b1;
                    end else begin
                        commitReq = 1'b1;
                    end
                end
            end else if (addr_i == STATUS_ADDR) begin
                if (we_i) begin
                    err_d = 1'b1;
                end else begin
                    rdata_d = {31'h0, busy_o};
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Per-pin comparison of the shadow image against the live selects.
    always_comb begin
        chgNow = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            chgNow[i] = (shadow_q[i*SEL_W +: SEL_W] != active_q[i*SEL_W +: SEL_W]);
        end
    end

    // Switch sequencer: gate changed pins, swap selects, hold, then release.
    always_comb begin
        state_d    = state_q;
        guardCnt_d = guardCnt_q;
        pend_d     = pend_q;
        active_d   = active_q;
        chg_d      = chg_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (commitReq) begin
                    if (chgNow != '0) begin
                        state_d    = GATE;
                        guardCnt_d = GUARD_LOAD;
                        pend_d     = shadow_q;
                        chg_d      = chgNow;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            GATE: begin
                if (guardCnt_q == CNT_ONE) begin
                    state_d = SWITCH;
                end else begin
                    guardCnt_d = guardCnt_q - CNT_ONE;
                end
            end
            SWITCH: begin
                active_d   = pend_q;
                state_d    = HOLD;
                guardCnt_d = GUARD_LOAD;
            end
            HOLD: begin
                if (guardCnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    chg_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    guardCnt_d = guardCnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and register update; reset aborts any running sequence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            guardCnt_q <= '0;
            shadow_q   <= '0;
            pend_q     <= '0;
            active_q   <= '0;
            chg_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            guardCnt_q <= guardCnt_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            active_q   <= active_d;
            chg_q      <= chg_d;
            rvalid_q   <= req_i;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

endmodule
